frame_window: RTL and testbench

- Programmable frame-window watchdog.
- A synchronous restart pulse (WDRST) opens a window of FWLEN clock cycles. A service pulse (WDSRVC) re-arms the window. If the window elapses without service, the sticky overflow flag FWOVR asserts.
- Sits beside the frame-timing logic; FWOVR feeds the fault/recovery controller.

---
 rtl/frame_window.sv | 54 +++++
 tb/tb_frame_window.sv | 114 +++++++++++
 2 files changed

// File: rtl/frame_window.sv
// frame_window: frame-window watchdog; WDRST opens an FWLEN-cycle window, WDSRVC re-arms it, sticky FWOVR flags expiry, FWCNT/FWACT expose count and armed state
module frame_window #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             WDRST,
  input  logic             WDSRVC,
  input  logic [CNT_W-1:0] FWLEN,
  output logic             FWOVR,
  output logic [CNT_W-1:0] FWCNT,
  output logic             FWACT
);
  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, len_q, len_n, cnt_inc;
  logic ovr_n;
  assign cnt_inc = cnt + 1'b1;
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      state <= IDLE;
      cnt   <= '0;
      len_q <= '0;
      FWOVR <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      len_q <= len_n;
      FWOVR <= ovr_n;
    end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    len_n   = len_q;
    ovr_n   = FWOVR;
    if (WDRST) begin
      state_n = RUN;
      cnt_n   = '0;
      len_n   = FWLEN;
      ovr_n   = 1'b0;
    end else if (state == RUN) begin
      if (WDSRVC) cnt_n = '0;
      else if (len_q != '0) begin
        state_n = (cnt_inc == len_q) ? EXPIRED : RUN;
        ovr_n   = (cnt_inc == len_q);
        cnt_n   = cnt_inc;
      end
    end
  end
  always_comb begin
    FWACT = (state == RUN);
    FWCNT = cnt;
  end
endmodule

// File: tb/tb_frame_window.sv
// tb_frame_window: directed vector bench for the frame-window watchdog
module tb_frame_window;
  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        WDRST = 1'b0;
  logic        WDSRVC = 1'b0;
  logic [15:0] FWLEN = '0;
  logic        FWOVR;
  logic [15:0] FWCNT;
  logic        FWACT;
  int          passed = 0;
  int          total = 0;
  typedef struct {
    logic        r;
    logic        s;
    logic [15:0] l;
    logic        o;
    logic        a;
    logic [15:0] c;
  } vec_t;
  vec_t vecs[$];
  frame_window #(.CNT_W(16)) dut (
    .CLK(CLK), .RSTN(RSTN), .WDRST(WDRST), .WDSRVC(WDSRVC),
    .FWLEN(FWLEN), .FWOVR(FWOVR), .FWCNT(FWCNT), .FWACT(FWACT)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic chk_all(input string tag, input logic o, input logic a, input logic [15:0] c);
    chk({tag, " ovr"}, 32'(FWOVR), 32'(o));
    chk({tag, " act"}, 32'(FWACT), 32'(a));
    chk({tag, " cnt"}, 32'(FWCNT), 32'(c));
  endtask
  task automatic add(input logic r, input logic s, input logic [15:0] l, input logic o, input logic a, input logic [15:0] c);
    vec_t v;
    v.r = r; v.s = s; v.l = l; v.o = o; v.a = a; v.c = c;
    vecs.push_back(v);
  endtask
  task automatic step(input logic r, input logic s, input logic [15:0] l);
    @(negedge CLK);
    WDRST = r;
    WDSRVC = s;
    FWLEN = l;
    @(posedge CLK);
    #1;
  endtask
  initial begin
    add(0, 1, 6, 0, 0, 0);
    add(0, 0, 6, 0, 0, 0);
    add(1, 0, 6, 0, 1, 0);
    for (int i = 1; i <= 3; i++) add(0, 0, 6, 0, 1, 16'(i));
    add(0, 1, 6, 0, 1, 0);
    for (int i = 1; i <= 5; i++) add(0, 0, 6, 0, 1, 16'(i));
    add(0, 0, 6, 1, 0, 6);
    add(0, 1, 6, 1, 0, 6);
    add(0, 0, 6, 1, 0, 6);
    add(1, 0, 6, 0, 1, 0);
    for (int i = 1; i <= 5; i++) add(0, 0, 16'(i + 1), 0, 1, 16'(i));
    add(0, 0, 2, 1, 0, 6);
    add(0, 1, 2, 1, 0, 6);
    add(1, 1, 6, 0, 1, 0);
    for (int i = 1; i <= 5; i++) add(0, 0, 6, 0, 1, 16'(i));
    add(0, 1, 6, 0, 1, 0);
    add(0, 0, 6, 0, 1, 1);
    for (int i = 2; i <= 5; i++) add(0, 0, 6, 0, 1, 16'(i));
    add(1, 0, 3, 0, 1, 0);
    add(0, 0, 3, 0, 1, 1);
    add(0, 0, 3, 0, 1, 2);
    add(0, 0, 3, 1, 0, 3);
    add(1, 0, 1, 0, 1, 0);
    add(0, 0, 1, 1, 0, 1);
    add(0, 1, 1, 1, 0, 1);
    add(1, 0, 16'hffff, 0, 1, 0);
    add(0, 0, 16'hffff, 0, 1, 1);
    repeat (2) @(posedge CLK);
    #1;
    chk_all("reset", 0, 0, 0);
    @(negedge CLK);
    RSTN = 1'b1;
    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].s, vecs[i].l);
      chk_all($sformatf("vec%0d", i), vecs[i].o, vecs[i].a, vecs[i].c);
    end
    step(1, 0, 0);
    chk_all("len0 start", 0, 1, 0);
    for (int i = 0; i < 100; i++) begin
      step(0, 0, 0);
      chk_all($sformatf("len0 cyc%0d", i), 0, 1, 0);
    end
    step(1, 0, 6);
    for (int i = 1; i <= 3; i++) step(0, 0, 6);
    chk_all("pre async", 0, 1, 3);
    #1 RSTN = 1'b0;
    #1 chk_all("async run", 0, 0, 0);
    @(negedge CLK);
    RSTN = 1'b1;
    step(0, 0, 6);
    chk_all("idle after async", 0, 0, 0);
    step(1, 0, 1);
    step(0, 0, 1);
    chk_all("pre async exp", 1, 0, 1);
    #1 RSTN = 1'b0;
    #1 chk_all("async exp", 0, 0, 0);
    @(negedge CLK);
    RSTN = 1'b1;
    step(0, 1, 1);
    chk_all("idle srvc", 0, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
